// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute,
// memory and writeback, and tracks retired instructions, illegal opcodes and bus timeouts.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fn3,
    input  logic             br_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);
    localparam int unsigned       WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
        CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
    } cls_t;

    state_t            state;
    cls_t              cls;
    cls_t              dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              sel_a;
    logic              sel_b;
    logic              timed_out;

    always_comb begin
        dec_cls = CL_ILLEGAL;
        case (opcode)
            OPC_OP:     dec_cls = CL_OP;
            OPC_OPIMM:  dec_cls = CL_OPIMM;
            OPC_LOAD:   dec_cls = (fn3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                                  ? CL_LOAD : CL_ILLEGAL;
            OPC_STORE:  dec_cls = (fn3 inside {3'b000, 3'b001, 3'b010}) ? CL_STORE : CL_ILLEGAL;
            OPC_BRANCH: dec_cls = (fn3 inside {3'b010, 3'b011}) ? CL_ILLEGAL : CL_BRANCH;
            OPC_JAL:    dec_cls = CL_JAL;
            OPC_JALR:   dec_cls = (fn3 == 3'b000) ? CL_JALR : CL_ILLEGAL;
            OPC_LUI:    dec_cls = CL_LUI;
            OPC_AUIPC:  dec_cls = CL_AUIPC;
            OPC_FENCE:  dec_cls = CL_FENCE;
            OPC_SYSTEM: dec_cls = CL_SYSTEM;
            default:    dec_cls = CL_ILLEGAL;
        endcase
    end

    assign wait_nxt  = wait_cnt + 1'b1;
    assign timed_out = (wait_nxt == WAIT_MAX);
    assign sel_a     = cls inside {CL_AUIPC, CL_JAL, CL_BRANCH};
    assign sel_b     = (cls != CL_OP);

    // The wait counter defaults to clear each cycle; only the two wait states
    // let it run, so it is zero on every state entry and after every ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            cls      <= CL_OP;
            wait_cnt <= '0;
            instret  <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        state <= DECODE;
                    end else if (timed_out) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                DECODE: begin
                    cls <= dec_cls;
                    case (dec_cls)
                        CL_ILLEGAL: begin
                            state   <= HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                        CL_SYSTEM: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: begin
                    case (cls)
                        CL_BRANCH, CL_FENCE: begin
                            state   <= FETCH;
                            instret <= instret + 1'b1;
                        end
                        CL_LOAD, CL_STORE: state <= MEM;
                        default:           state <= WB;
                    endcase
                end
                MEM: begin
                    if (dmem_ack) begin
                        if (cls == CL_STORE) begin
                            state   <= FETCH;
                            instret <= instret + 1'b1;
                        end else begin
                            state <= WB;
                        end
                    end else if (timed_out) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                WB: begin
                    state   <= FETCH;
                    instret <= instret + 1'b1;
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Gated by rst_n so nothing is requested while reset is held.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                EXEC: begin
                    alu_a_sel = sel_a;
                    alu_b_sel = sel_b;
                    if (cls == CL_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'b01 : 2'b00;
                    end else if (cls == CL_FENCE) begin
                        pc_we = 1'b1;
                    end
                end
                MEM: begin
                    dmem_req  = 1'b1;
                    dmem_we   = (cls == CL_STORE);
                    alu_a_sel = sel_a;
                    alu_b_sel = sel_b;
                    pc_we     = dmem_ack && (cls == CL_STORE);
                end
                WB: begin
                    rf_we = 1'b1;
                    pc_we = 1'b1;
                    case (cls)
                        CL_LOAD:         wb_sel = 2'b01;
                        CL_JAL, CL_JALR: wb_sel = 2'b10;
                        CL_LUI:          wb_sel = 2'b11;
                        default:         wb_sel = 2'b00;
                    endcase
                    case (cls)
                        CL_JAL:  pc_sel = 2'b01;
                        CL_JALR: pc_sel = 2'b10;
                        default: pc_sel = 2'b00;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors are
// queued with their stimulus and compared as the DUT steps through each instruction.
module tb_multicycle_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  fn3;
    logic        br_taken;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic        ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel;
    logic [1:0]  pc_sel, wb_sel;
    logic        halted, illegal, bus_err;
    logic [31:0] instret;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .fn3(fn3), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .halted(halted),
        .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       a_sel, b_sel, halted, illegal, bus_err;
    } ctl_t;

    typedef struct packed {
        logic imem_ack, dmem_ack, br_taken;
    } in_t;

    in_t         in_q[$];
    ctl_t        exp_q[$];
    logic [31:0] cnt_q[$];
    logic [31:0] exp_instret;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          step  = 0;

    function automatic ctl_t dut_ctl();
        ctl_t g;
        g = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
             alu_a_sel, alu_b_sel, halted, illegal, bus_err};
        return g;
    endfunction

    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'h33, 7'h13, 7'h6f, 7'h37, 7'h17, 7'h0f, 7'h73: return 1'b1;
            7'h03:   return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            7'h23:   return f3 <= 3'd2;
            7'h63:   return (f3 != 3'd2) && (f3 != 3'd3);
            7'h67:   return f3 == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input in_t i, input ctl_t e);
        in_q.push_back(i);
        exp_q.push_back(e);
        cnt_q.push_back(exp_instret);
    endtask

    task automatic push_halt(input logic ill, input logic be);
        in_t  i;
        ctl_t e;
        i = '{imem_ack: 1'b1, dmem_ack: 1'b1, br_taken: 1'b1};
        e = '0;
        e.halted  = 1'b1;
        e.illegal = ill;
        e.bus_err = be;
        for (int k = 0; k < 3; k++) push(i, e);
    endtask

    // Drive each queued input at posedge+1, compare at the following negedge.
    task automatic play();
        in_t         i;
        ctl_t        e;
        ctl_t        g;
        logic [31:0] c;
        while (exp_q.size() > 0) begin
            i = in_q.pop_front();
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            imem_ack = i.imem_ack;
            dmem_ack = i.dmem_ack;
            br_taken = i.br_taken;
            @(negedge clk);
            g = dut_ctl();
            n_cmp++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL ctl step=%0d got=%b want=%b", step, g, e);
            end
            n_cmp++;
            if (instret !== c) begin
                n_mis++;
                $display("FAIL instret step=%0d got=%0d want=%0d", step, instret, c);
            end
            step++;
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic br, input logic noise, input bit cut);
        logic [6:0] op;
        logic [2:0] f3;
        in_t        i;
        ctl_t       e;
        ctl_t       sel;
        op = ins[6:0];
        f3 = ins[14:12];
        opcode = op;
        fn3    = f3;
        // fetch
        i = '{imem_ack: 1'b0, dmem_ack: noise, br_taken: noise};
        e = '0;
        e.imem_req = 1'b1;
        for (int k = 0; k < iw && k < TIMEOUT; k++) push(i, e);
        if (iw >= TIMEOUT) begin
            push_halt(1'b0, 1'b1);
            play();
            return;
        end
        i.imem_ack = 1'b1;
        e.ir_we    = 1'b1;
        push(i, e);
        // decode
        i = '{imem_ack: noise, dmem_ack: noise, br_taken: noise};
        e = '0;
        push(i, e);
        if (!is_legal(op, f3)) begin
            push_halt(1'b1, 1'b0);
            play();
            return;
        end
        if (op == 7'h73) begin
            push_halt(1'b0, 1'b0);
            play();
            return;
        end
        // exec
        sel = '0;
        sel.a_sel = (op == 7'h17) || (op == 7'h6f) || (op == 7'h63);
        sel.b_sel = (op != 7'h33);
        e = sel;
        if (op == 7'h63 || op == 7'h0f) begin
            e.pc_we  = 1'b1;
            e.pc_sel = (op == 7'h63 && br) ? 2'b01 : 2'b00;
            i.br_taken = (op == 7'h63) ? br : noise;
            push(i, e);
            exp_instret++;
            play();
            return;
        end
        push(i, e);
        // memory
        if (op == 7'h03 || op == 7'h23) begin
            i = '{imem_ack: noise, dmem_ack: 1'b0, br_taken: noise};
            e = sel;
            e.dmem_req = 1'b1;
            e.dmem_we  = (op == 7'h23);
            for (int k = 0; k < dw && k < TIMEOUT; k++) begin
                push(i, e);
                if (cut) begin
                    play();
                    return;
                end
            end
            if (dw >= TIMEOUT) begin
                push_halt(1'b0, 1'b1);
                play();
                return;
            end
            i.dmem_ack = 1'b1;
            if (op == 7'h23) begin
                e.pc_we = 1'b1;
                push(i, e);
                exp_instret++;
                play();
                return;
            end
            push(i, e);
        end
        // writeback
        i = '{imem_ack: noise, dmem_ack: noise, br_taken: noise};
        e = '0;
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        case (op)
            7'h6f: begin e.wb_sel = 2'b10; e.pc_sel = 2'b01; end
            7'h67: begin e.wb_sel = 2'b10; e.pc_sel = 2'b10; end
            7'h37: e.wb_sel = 2'b11;
            7'h03: e.wb_sel = 2'b01;
            default: ;
        endcase
        push(i, e);
        exp_instret++;
        play();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_ctl() !== ctl_t'('0)) begin
            n_mis++;
            $display("FAIL reset_ctl got=%b want=0", dut_ctl());
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (instret !== 32'd0 || imem_req !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_hold instret=%0d imem_req=%b want 0/0", instret, imem_req);
        end
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    task automatic test_alu();
        run_instr(32'h00848933, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h10100493, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr(32'h41425313, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (instret !== 32'd3) begin
            n_mis++;
            $display("FAIL alu_instret got=%0d want=3", instret);
        end
    endtask

    task automatic test_load_store();
        run_instr(32'h0082a223, 0, 2, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0002a303, 0, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        run_instr(32'h014c6463, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(32'h014c6463, 1, 0, 1'b0, 1'b1, 1'b0);
        run_instr(32'h0000000f, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_jumps();
        run_instr(32'h7ff080e7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000006f, 0, 0, 1'b0, 1'b1, 1'b0);
        run_instr(32'h872370b7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h10000917, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        do_reset();
        run_instr(32'h0000a023, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000b023, 0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(32'h0000007f, 0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(32'h00000073, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (halted !== 1'b1 || illegal !== 1'b0) begin
            n_mis++;
            $display("FAIL system_halt halted=%b illegal=%b want 1/0", halted, illegal);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        run_instr(32'h10100493, TIMEOUT - 1, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0002a303, 0, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        run_instr(32'h10100493, TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(32'h0002a303, 0, TIMEOUT, 1'b0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_reset_mid_mem();
        run_instr(32'h00848933, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0082a223, 0, 3, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (dut_ctl() !== ctl_t'('0) || instret !== 32'd0) begin
            n_mis++;
            $display("FAIL mid_mem_reset ctl=%b instret=%0d want 0/0", dut_ctl(), instret);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_instret = '0;
        run_instr(32'h00848933, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        opcode = '0;
        fn3 = '0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        exp_instret = '0;
        #2;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
